// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector: state width, default
// pattern and the prefix-automaton next-state function.
package seq_det_pkg;

    localparam int STATE_W = 2;
    localparam logic [2:0] SEQ_101 = 3'b101;

    // Longest suffix of (first q pattern bits, b) that is also a pattern prefix.
    // A full match without overlap restarts from empty history.
    function automatic logic [STATE_W-1:0] seq_next_state(
        input logic [2:0]         pattern,
        input logic [STATE_W-1:0] q,
        input logic               b,
        input logic               overlap
    );
        logic [3:0]         h;
        logic [STATE_W-1:0] res;
        logic               ok;
        int                 qe;
        int                 len;
        qe  = (q == 2'd3 && !overlap) ? 0 : int'(q);
        h   = '0;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < qe) h[i] = pattern[2-i];
        end
        h[qe] = b;
        len   = qe + 1;
        for (int k = 1; k <= 3; k++) begin
            if (k <= len) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (h[len-k+j] != pattern[2-j]) ok = 1'b0;
                end
                if (ok) res = STATE_W'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_sequence_detector.sv
// Bit-serial detector for a fixed 3-bit pattern (MSB received first); the
// registered detect pulse marks each completed match.
module serial_sequence_detector
    import seq_det_pkg::*;
#(
    parameter logic [2:0] PATTERN = SEQ_101,
    parameter bit         OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic si,
    output logic detected
);

    logic [STATE_W-1:0] q;
    logic [STATE_W-1:0] q_next;

    always_comb begin
        q_next = seq_next_state(PATTERN, q, si, OVERLAP);
    end

    // detected mirrors q == 3 but comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            detected <= 1'b0;
        end else begin
            q        <= q_next;
            detected <= (q_next == 2'd3);
        end
    end

endmodule

// File: tb/tb_serial_sequence_detector.sv
// Scoreboard bench: four detector configurations share one serial stream and
// are compared against a reference model every cycle, plus literal directed cases.
module tb_serial_sequence_detector;
    import seq_det_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       si;
    logic [3:0] det;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0]         pat [4] = '{3'b101, 3'b101, 3'b111, 3'b000};
    logic               ov  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [STATE_W-1:0] m_q [4];
    logic [3:0]         exp_q [$];

    always #5 clk = ~clk;

    serial_sequence_detector #(.PATTERN(3'b101), .OVERLAP(1'b1)) u_101_ov
        (.clk(clk), .rst_n(rst_n), .si(si), .detected(det[0]));
    serial_sequence_detector #(.PATTERN(3'b101), .OVERLAP(1'b0)) u_101_no
        (.clk(clk), .rst_n(rst_n), .si(si), .detected(det[1]));
    serial_sequence_detector #(.PATTERN(3'b111), .OVERLAP(1'b1)) u_111
        (.clk(clk), .rst_n(rst_n), .si(si), .detected(det[2]));
    serial_sequence_detector #(.PATTERN(3'b000), .OVERLAP(1'b1)) u_000
        (.clk(clk), .rst_n(rst_n), .si(si), .detected(det[3]));

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send(input logic b);
        logic [3:0] e;
        si = b;
        for (int i = 0; i < 4; i++) begin
            m_q[i] = seq_next_state(pat[i], m_q[i], b, ov[i]);
            e[i]   = (m_q[i] == 2'd3);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            chk("model_101_ov", det[0], e[0]);
            chk("model_101_no", det[1], e[1]);
            chk("model_111",    det[2], e[2]);
            chk("model_000",    det[3], e[3]);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear with no clock.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_rst_det%0d", i), det[i], 1'b0);
            m_q[i] = '0;
        end
        exp_q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    // Feed n bits (bits[n-1] first) and compare one DUT against literal pulses.
    task automatic seqchk(input string tag, input logic [7:0] bits,
                          input logic [7:0] exp, input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            send(bits[n-1-i]);
            chk($sformatf("%s_b%0d", tag, i + 1), det[idx], exp[n-1-i]);
        end
    endtask

    initial begin
        int seed;
        logic r;
        si    = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) m_q[i] = '0;
        #3;
        for (int i = 0; i < 4; i++) chk($sformatf("rst_det%0d", i), det[i], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: zeros after reset never match 101
        seqchk("t1_zeros", 8'b000, 8'b000, 0, 3);

        // T2: single match, one-cycle pulse
        pulse_reset();
        seqchk("t2_101", 8'b1010, 8'b0010, 0, 4);

        // T3: overlap vs no overlap
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            send(i[0] ? 1'b0 : 1'b1);
            chk($sformatf("t3_ov_b%0d", i + 1), det[0], (i == 2 || i == 4));
            chk($sformatf("t3_no_b%0d", i + 1), det[1], (i == 2));
        end

        // T4: near-miss streams
        pulse_reset();
        seqchk("t4_1101", 8'b1101, 8'b0001, 0, 4);
        pulse_reset();
        seqchk("t4_1001", 8'b1001, 8'b0000, 0, 4);

        // T5: reset mid-sequence discards the partial match
        pulse_reset();
        seqchk("t5_pre", 8'b10, 8'b00, 0, 2);
        pulse_reset();
        seqchk("t5_post", 8'b101, 8'b001, 0, 3);

        // Self-overlapping patterns
        pulse_reset();
        seqchk("p111_run", 8'b11111, 8'b00111, 2, 5);
        pulse_reset();
        seqchk("p000_run", 8'b0000, 8'b0011, 3, 4);

        // T6: random stream against the reference model
        pulse_reset();
        seed = 4;
        for (int i = 0; i < 1000; i++) begin
            r = 1'($random(seed));
            send(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
